// File: rtl/uart_cmd_pkt_if.sv
// Bundle of UART byte, command and response handshake signals for uart_cmd_pkt.
//   rx_rdy/rx_data/clr_rx_rdy          : received-byte handshake with the UART
//   cmd/cmd_rdy/clr_cmd_rdy/frame_err  : assembled command to the consumer
//   resp/send_resp/resp_busy/resp_done : response request from the consumer
//   trmt/tx_data/tx_done               : transmit-byte handshake with the UART
// slave is the packetiser view; master is the surrounding system view.
interface uart_cmd_pkt_if #(
    parameter int unsigned CMD_BYTES  = 2,
    parameter int unsigned RESP_BYTES = 1
);
    logic                    rx_rdy;
    logic [7:0]              rx_data;
    logic                    clr_rx_rdy;
    logic [8*CMD_BYTES-1:0]  cmd;
    logic                    cmd_rdy;
    logic                    clr_cmd_rdy;
    logic                    frame_err;
    logic [8*RESP_BYTES-1:0] resp;
    logic                    send_resp;
    logic                    resp_busy;
    logic                    trmt;
    logic [7:0]              tx_data;
    logic                    tx_done;
    logic                    resp_done;

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, frame_err, resp_busy, trmt, tx_data, resp_done
    );

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, frame_err, resp_busy, trmt, tx_data, resp_done
    );
endinterface

// File: rtl/uart_cmd_pkt.sv
// Byte-to-command packetiser between a byte UART and a command consumer.
//   RX: assembles CMD_BYTES bytes (first byte -> MSB) into cmd, flags cmd_rdy,
//       drops partial frames after TIMEOUT_CYC idle cycles (frame_err pulse).
//   TX: sends a RESP_BYTES response MSB first as back-to-back trmt/tx_done bytes.
// Ports: clk, rst_n (async active-low), bus (uart_cmd_pkt_if.slave).
module uart_cmd_pkt #(
    parameter int unsigned CMD_BYTES   = 2,
    parameter int unsigned RESP_BYTES  = 1,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_cmd_pkt_if.slave bus
);

    localparam int unsigned CMD_W  = 8 * CMD_BYTES;
    localparam int unsigned RESP_W = 8 * RESP_BYTES;
    localparam int unsigned CNT_W  = $clog2(CMD_BYTES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned IDX_W  = $clog2(RESP_BYTES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_BYTES);
    // frame_err is registered, so the fire decision is taken one cycle early
    localparam logic [TO_W-1:0]  TO_FIRE  = TO_W'(TIMEOUT_CYC - 2);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BYTES - 1);

    typedef enum logic {RX_IDLE, RX_COLLECT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

    rx_state_t         r_rx_state;
    logic [CMD_W-1:0]  r_asm;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [CMD_W-1:0]  r_cmd;
    logic              r_cmd_rdy;
    logic              r_frame_err;

    tx_state_t         r_tx_state;
    logic [RESP_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_idx;
    logic              r_resp_busy;
    logic              r_trmt;
    logic [7:0]        r_tx_data;
    logic              r_resp_done;

    logic [CMD_W-1:0]  w_asm_next;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [RESP_W-1:0] w_shift_next;

    // A byte in IDLE always starts a fresh frame, whatever byte_cnt holds
    assign w_asm_next   = (r_asm << 8) | CMD_W'(bus.rx_data);
    assign w_cnt_next   = ((r_rx_state == RX_IDLE) ? '0 : r_byte_cnt) + CNT_W'(1);
    assign w_shift_next = r_shift << 8;

    assign bus.clr_rx_rdy = bus.rx_rdy;
    assign bus.cmd        = r_cmd;
    assign bus.cmd_rdy    = r_cmd_rdy;
    assign bus.frame_err  = r_frame_err;
    assign bus.resp_busy  = r_resp_busy;
    assign bus.trmt       = r_trmt;
    assign bus.tx_data    = r_tx_data;
    assign bus.resp_done  = r_resp_done;

    // RX framing FSM: byte assembly, inter-byte timeout, cmd_rdy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state  <= RX_IDLE;
            r_asm       <= '0;
            r_byte_cnt  <= '0;
            r_to_cnt    <= '0;
            r_cmd       <= '0;
            r_cmd_rdy   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (bus.clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
            case (r_rx_state)
                RX_IDLE: begin
                    if (bus.rx_rdy) begin
                        r_to_cnt  <= '0;
                        r_asm     <= w_asm_next;
                        r_cmd_rdy <= 1'b0;
                        if (w_cnt_next == CNT_LAST) begin
                            // later assignment: completion beats any clear
                            r_cmd      <= w_asm_next;
                            r_cmd_rdy  <= 1'b1;
                            r_byte_cnt <= '0;
                        end else begin
                            r_byte_cnt <= w_cnt_next;
                            r_rx_state <= RX_COLLECT;
                        end
                    end
                end
                RX_COLLECT: begin
                    if (bus.rx_rdy) begin
                        // a byte arriving on the timeout cycle still counts
                        r_to_cnt <= '0;
                        r_asm    <= w_asm_next;
                        if (w_cnt_next == CNT_LAST) begin
                            r_cmd      <= w_asm_next;
                            r_cmd_rdy  <= 1'b1;
                            r_byte_cnt <= '0;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_byte_cnt <= w_cnt_next;
                        end
                    end else if (r_to_cnt == TO_FIRE) begin
                        r_frame_err <= 1'b1;
                        r_asm       <= '0;
                        r_byte_cnt  <= '0;
                        r_to_cnt    <= '0;
                        r_rx_state  <= RX_IDLE;
                    end else if (r_to_cnt != TO_MAX) begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // TX response FSM: one trmt per byte, next byte on each tx_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state  <= TX_IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_resp_busy <= 1'b0;
            r_trmt      <= 1'b0;
            r_tx_data   <= '0;
            r_resp_done <= 1'b0;
        end else begin
            r_trmt      <= 1'b0;
            r_resp_done <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (bus.send_resp) begin
                        // trmt is raised on entry so it is visible during SEND
                        r_shift     <= bus.resp;
                        r_idx       <= '0;
                        r_resp_busy <= 1'b1;
                        r_trmt      <= 1'b1;
                        r_tx_data   <= bus.resp[RESP_W-1 -: 8];
                        r_tx_state  <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    r_tx_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (bus.tx_done) begin
                        if (r_idx != IDX_LAST) begin
                            r_shift    <= w_shift_next;
                            r_idx      <= r_idx + IDX_W'(1);
                            r_trmt     <= 1'b1;
                            r_tx_data  <= w_shift_next[RESP_W-1 -: 8];
                            r_tx_state <= TX_SEND;
                        end else begin
                            r_resp_done <= 1'b1;
                            r_resp_busy <= 1'b0;
                            r_tx_state  <= TX_IDLE;
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_pkt.sv
// Directed testbench for uart_cmd_pkt with a command/response scoreboard.
//   dut_a: CMD_BYTES=2, RESP_BYTES=2, TIMEOUT_CYC=20
//   dut_b: CMD_BYTES=3, RESP_BYTES=1, TIMEOUT_CYC=20
module tb_uart_cmd_pkt;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] q_cmd[$];
    logic [7:0]  q_tx[$];

    uart_cmd_pkt_if #(.CMD_BYTES(2), .RESP_BYTES(2)) bus_a ();
    uart_cmd_pkt_if #(.CMD_BYTES(3), .RESP_BYTES(1)) bus_b ();

    uart_cmd_pkt #(.CMD_BYTES(2), .RESP_BYTES(2), .TIMEOUT_CYC(20)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    uart_cmd_pkt #(.CMD_BYTES(3), .RESP_BYTES(1), .TIMEOUT_CYC(20)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One byte in one cycle; clr_rx_rdy must follow rx_rdy combinationally
    task automatic send_byte(input bit sel, input logic [7:0] b, input logic clr_same);
        if (sel) begin
            bus_b.rx_rdy = 1'b1; bus_b.rx_data = b; bus_b.clr_cmd_rdy = clr_same;
        end else begin
            bus_a.rx_rdy = 1'b1; bus_a.rx_data = b; bus_a.clr_cmd_rdy = clr_same;
        end
        #1;
        chk("clr_rx_rdy_hi", 64'(sel ? bus_b.clr_rx_rdy : bus_a.clr_rx_rdy), 64'd1);
        tick();
        if (sel) begin
            bus_b.rx_rdy = 1'b0; bus_b.clr_cmd_rdy = 1'b0;
        end else begin
            bus_a.rx_rdy = 1'b0; bus_a.clr_cmd_rdy = 1'b0;
        end
        #1;
        chk("clr_rx_rdy_lo", 64'(sel ? bus_b.clr_rx_rdy : bus_a.clr_rx_rdy), 64'd0);
    endtask

    task automatic expect_cmd(input bit sel, input string tag);
        logic [31:0] e;
        chk({tag, "_sb_nonempty"}, 64'(q_cmd.size() != 0), 64'd1);
        if (q_cmd.size() != 0) begin
            e = q_cmd.pop_front();
            chk({tag, "_cmd"}, 64'(sel ? 32'(bus_b.cmd) : 32'(bus_a.cmd)), 64'(e));
            chk({tag, "_cmd_rdy"}, 64'(sel ? bus_b.cmd_rdy : bus_a.cmd_rdy), 64'd1);
        end
    endtask

    task automatic expect_tx(input bit sel, input string tag);
        logic [7:0] e;
        chk({tag, "_sb_nonempty"}, 64'(q_tx.size() != 0), 64'd1);
        if (q_tx.size() != 0) begin
            e = q_tx.pop_front();
            chk({tag, "_trmt"}, 64'(sel ? bus_b.trmt : bus_a.trmt), 64'd1);
            chk({tag, "_tx_data"}, 64'(sel ? bus_b.tx_data : bus_a.tx_data), 64'(e));
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_cmd"},       64'(bus_a.cmd),       64'd0);
        chk({tag, "_cmd_rdy"},   64'(bus_a.cmd_rdy),   64'd0);
        chk({tag, "_frame_err"}, 64'(bus_a.frame_err), 64'd0);
        chk({tag, "_resp_busy"}, 64'(bus_a.resp_busy), 64'd0);
        chk({tag, "_trmt"},      64'(bus_a.trmt),      64'd0);
        chk({tag, "_tx_data"},   64'(bus_a.tx_data),   64'd0);
        chk({tag, "_resp_done"}, 64'(bus_a.resp_done), 64'd0);
    endtask

    initial begin
        int cycles;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus_a.rx_rdy = 1'b0; bus_a.rx_data = '0; bus_a.clr_cmd_rdy = 1'b0;
        bus_a.resp = '0; bus_a.send_resp = 1'b0; bus_a.tx_done = 1'b0;
        bus_b.rx_rdy = 1'b0; bus_b.rx_data = '0; bus_b.clr_cmd_rdy = 1'b0;
        bus_b.resp = '0; bus_b.send_resp = 1'b0; bus_b.tx_done = 1'b0;

        #12;
        chk_reset_a("rst_a");
        chk("rst_b_cmd", 64'(bus_b.cmd), 64'd0);
        chk("rst_b_trmt", 64'(bus_b.trmt), 64'd0);
        #5 rst_n = 1'b1;
        tick();

        // two-byte command, MSB first
        send_byte(1'b0, 8'hA5, 1'b0);
        chk("a5_partial_cmd_rdy", 64'(bus_a.cmd_rdy), 64'd0);
        chk("a5_partial_cmd", 64'(bus_a.cmd), 64'd0);
        q_cmd.push_back(32'hA53C);
        send_byte(1'b0, 8'h3C, 1'b0);
        expect_cmd(1'b0, "a53c");

        // consumer acknowledge; cmd is held
        bus_a.clr_cmd_rdy = 1'b1;
        tick();
        bus_a.clr_cmd_rdy = 1'b0;
        chk("ack_cmd_rdy", 64'(bus_a.cmd_rdy), 64'd0);
        chk("ack_cmd_hold", 64'(bus_a.cmd), 64'hA53C);

        // three-byte command, then a lone first byte clears cmd_rdy
        send_byte(1'b1, 8'h12, 1'b0);
        send_byte(1'b1, 8'h34, 1'b0);
        q_cmd.push_back(32'h123456);
        send_byte(1'b1, 8'h56, 1'b0);
        expect_cmd(1'b1, "c3");
        send_byte(1'b1, 8'h78, 1'b0);
        chk("c3_new_first_cmd_rdy", 64'(bus_b.cmd_rdy), 64'd0);
        chk("c3_new_first_cmd", 64'(bus_b.cmd), 64'h123456);

        // timeout of a partial frame: frame_err exactly 20 cycles after the byte
        send_byte(1'b0, 8'hAA, 1'b0);
        cycles = 1;
        while (bus_a.frame_err !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        chk("timeout_latency", 64'(cycles), 64'd20);
        chk("timeout_cmd_hold", 64'(bus_a.cmd), 64'hA53C);
        tick();
        chk("timeout_pulse_width", 64'(bus_a.frame_err), 64'd0);
        send_byte(1'b0, 8'h11, 1'b0);
        q_cmd.push_back(32'h1122);
        send_byte(1'b0, 8'h22, 1'b0);
        expect_cmd(1'b0, "resync");

        // completion and acknowledge in the same cycle: set wins
        send_byte(1'b0, 8'h33, 1'b0);
        q_cmd.push_back(32'h3344);
        send_byte(1'b0, 8'h44, 1'b1);
        expect_cmd(1'b0, "set_wins");

        // byte on the timeout cycle wins over the timeout
        send_byte(1'b0, 8'h55, 1'b0);
        repeat (18) tick();
        chk("pre_fire_frame_err", 64'(bus_a.frame_err), 64'd0);
        q_cmd.push_back(32'h5566);
        send_byte(1'b0, 8'h66, 1'b0);
        chk("race_frame_err", 64'(bus_a.frame_err), 64'd0);
        expect_cmd(1'b0, "race");
        tick();
        chk("race_frame_err_after", 64'(bus_a.frame_err), 64'd0);

        // two-byte response with a spurious send_resp mid-transfer
        bus_a.resp = 16'hBEEF;
        bus_a.send_resp = 1'b1;
        q_tx.push_back(8'hBE);
        q_tx.push_back(8'hEF);
        tick();
        bus_a.send_resp = 1'b0;
        chk("tx_busy_rise", 64'(bus_a.resp_busy), 64'd1);
        expect_tx(1'b0, "tx_be");
        tick();
        chk("tx_trmt_one_cycle", 64'(bus_a.trmt), 64'd0);
        chk("tx_data_stable", 64'(bus_a.tx_data), 64'hBE);
        bus_a.resp = 16'h1234;
        bus_a.send_resp = 1'b1;
        tick();
        bus_a.send_resp = 1'b0;
        chk("tx_ignore_trmt", 64'(bus_a.trmt), 64'd0);
        chk("tx_ignore_busy", 64'(bus_a.resp_busy), 64'd1);
        bus_a.tx_done = 1'b1;
        tick();
        bus_a.tx_done = 1'b0;
        expect_tx(1'b0, "tx_ef");
        chk("tx_no_early_done", 64'(bus_a.resp_done), 64'd0);
        tick();
        chk("tx_trmt_one_cycle2", 64'(bus_a.trmt), 64'd0);
        bus_a.tx_done = 1'b1;
        tick();
        bus_a.tx_done = 1'b0;
        chk("tx_resp_done", 64'(bus_a.resp_done), 64'd1);
        chk("tx_busy_fall", 64'(bus_a.resp_busy), 64'd0);
        chk("tx_no_trmt_at_end", 64'(bus_a.trmt), 64'd0);
        tick();
        chk("tx_resp_done_pulse", 64'(bus_a.resp_done), 64'd0);
        chk("tx_ignored_not_started", 64'(bus_a.trmt), 64'd0);
        chk("tx_sb_drained", 64'(q_tx.size()), 64'd0);

        // single-byte response
        bus_b.resp = 8'h5A;
        bus_b.send_resp = 1'b1;
        q_tx.push_back(8'h5A);
        tick();
        bus_b.send_resp = 1'b0;
        expect_tx(1'b1, "tx1");
        tick();
        bus_b.tx_done = 1'b1;
        tick();
        bus_b.tx_done = 1'b0;
        chk("tx1_resp_done", 64'(bus_b.resp_done), 64'd1);
        chk("tx1_busy_fall", 64'(bus_b.resp_busy), 64'd0);

        // asynchronous reset mid-frame and mid-response
        send_byte(1'b0, 8'h01, 1'b0);
        bus_a.resp = 16'hCAFE;
        bus_a.send_resp = 1'b1;
        tick();
        bus_a.send_resp = 1'b0;
        chk("prerst_trmt", 64'(bus_a.trmt), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_a("async_rst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_trmt", 64'(bus_a.trmt), 64'd0);
        end
        send_byte(1'b0, 8'h01, 1'b0);
        q_cmd.push_back(32'h0102);
        send_byte(1'b0, 8'h02, 1'b0);
        expect_cmd(1'b0, "post_rst");
        chk("cmd_sb_drained", 64'(q_cmd.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
